// File: rtl/jet_decide_pkg.sv
// -----------------------------------------------------------------------------
// jet_decide_pkg
//   Shared definitions for the jet-tagging class decider:
//     - state_t        : decider FSM states (IDLE -> SCAN -> HOLD -> IDLE)
//     - DEF_*          : default sizing of the softmax vector
//     - idx_t          : class index type for the default class count
//     - to_code()      : real -> signed fixed-point code, for building vectors
// -----------------------------------------------------------------------------
package jet_decide_pkg;

   localparam int DEF_OUTPUT_SIZE = 5;
   localparam int DEF_WIDTH       = 16;
   localparam int DEF_NFRAC       = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   typedef logic [$clog2(DEF_OUTPUT_SIZE)-1:0] idx_t;

   // Truncating conversion of a real value to a DEF_NFRAC fixed-point code.
   function automatic logic signed [DEF_WIDTH-1:0] to_code(input real r);
      return DEF_WIDTH'($rtoi(r * (2.0 ** DEF_NFRAC)));
   endfunction

endpackage

// File: rtl/class_counter_bank.sv
// -----------------------------------------------------------------------------
// class_counter_bank
//   Per-class and total saturating histogram counters for accepted decisions.
//   Ports:
//     clk, reset        : clock, asynchronous active-low reset
//     inc               : count one accepted decision of class inc_idx
//     inc_idx           : class index of the accepted decision
//     clear             : synchronous clear of all counters (wins over inc)
//     class_count       : packed per-class counts, class i at [i*CNT_WIDTH +: CNT_WIDTH]
//     total_count       : total accepted decisions
// -----------------------------------------------------------------------------
module class_counter_bank #(
   parameter int OUTPUT_SIZE = 5,
   parameter int CNT_WIDTH   = 32,
   parameter int IDX_W       = 3
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             inc,
   input  logic [IDX_W-1:0]                 inc_idx,
   input  logic                             clear,
   output logic [CNT_WIDTH*OUTPUT_SIZE-1:0] class_count,
   output logic [CNT_WIDTH-1:0]             total_count
);

   logic [CNT_WIDTH-1:0] r_cnt [OUTPUT_SIZE];
   logic [CNT_WIDTH-1:0] r_total;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < OUTPUT_SIZE; i++) r_cnt[i] <= '0;
         r_total <= '0;
      end else if (clear) begin
         for (int i = 0; i < OUTPUT_SIZE; i++) r_cnt[i] <= '0;
         r_total <= '0;
      end else if (inc) begin
         for (int i = 0; i < OUTPUT_SIZE; i++) begin
            if (inc_idx == IDX_W'(i)) r_cnt[i] <= sat_inc(r_cnt[i]);
         end
         r_total <= sat_inc(r_total);
      end
   end

   always_comb begin
      class_count = '0;
      for (int i = 0; i < OUTPUT_SIZE; i++) begin
         class_count[i*CNT_WIDTH +: CNT_WIDTH] = r_cnt[i];
      end
   end

   assign total_count = r_total;

endmodule

// File: rtl/jet_class_decider.sv
// -----------------------------------------------------------------------------
// jet_class_decider
//   Captures the softmax vector on a rising edge of in_valid, scans it one
//   entry per cycle for the arg-max, presents {class_idx, class_score,
//   low_conf} on a valid/ready handshake and histograms accepted decisions.
//   Ports:
//     clk, reset            : clock, asynchronous active-low reset
//     in_valid, in_data     : network output_ready level and softmax vector
//                             (entry i at [i*WIDTH +: WIDTH], signed)
//     out_valid, out_ready  : decision handshake
//     class_idx/class_score : winning class and its score
//     low_conf              : class_score < THRESH (signed)
//     busy                  : FSM not idle
//     overrun               : sticky, capture arrived while busy
//     clear_counts          : clears histogram and overrun
//     class_count, total_count : histogram outputs
// -----------------------------------------------------------------------------
module jet_class_decider
   import jet_decide_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int NFRAC       = 10,
   parameter int OUTPUT_SIZE = 5,
   parameter int CNT_WIDTH   = 32,
   parameter int THRESH      = 512
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  in_valid,
   input  logic [WIDTH*OUTPUT_SIZE-1:0]          in_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [$clog2(OUTPUT_SIZE)-1:0]        class_idx,
   output logic signed [WIDTH-1:0]               class_score,
   output logic                                  low_conf,
   output logic                                  busy,
   output logic                                  overrun,
   input  logic                                  clear_counts,
   output logic [CNT_WIDTH*OUTPUT_SIZE-1:0]      class_count,
   output logic [CNT_WIDTH-1:0]                  total_count
);

   localparam int IDX_W = $clog2(OUTPUT_SIZE);
   localparam int PTR_W = $clog2(OUTPUT_SIZE + 1);
   // The pointer runs one past the last entry; that extra SCAN cycle latches
   // the result into the output registers.
   localparam logic [PTR_W-1:0] PTR_DONE = PTR_W'(OUTPUT_SIZE);
   localparam logic signed [WIDTH-1:0] THRESH_S = WIDTH'(THRESH);

   state_t                  r_state;
   state_t                  w_state_next;
   logic                    r_in_valid_q;
   logic                    w_capture;
   logic                    w_accept;
   logic [PTR_W-1:0]        r_ptr;
   logic signed [WIDTH-1:0] r_buf [OUTPUT_SIZE];
   logic signed [WIDTH-1:0] r_max;
   logic [IDX_W-1:0]        r_idx;
   logic signed [WIDTH-1:0] w_entry;
   logic [IDX_W-1:0]        w_scan_idx;
   logic [IDX_W-1:0]        r_out_idx;
   logic signed [WIDTH-1:0] r_out_score;
   logic                    r_low_conf;
   logic                    r_overrun;

   function automatic logic is_low_conf(input logic signed [WIDTH-1:0] s);
      return s < THRESH_S;
   endfunction

   assign w_capture  = in_valid & ~r_in_valid_q;
   assign w_accept   = (r_state == ST_HOLD) & out_ready;
   assign w_scan_idx = IDX_W'(r_ptr);
   assign w_entry    = r_buf[w_scan_idx];

   // ---- control: state register and edge detect ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_in_valid_q <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_in_valid_q <= in_valid;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_capture)         w_state_next = ST_SCAN;
         ST_SCAN: if (r_ptr == PTR_DONE) w_state_next = ST_HOLD;
         ST_HOLD: if (w_accept)          w_state_next = ST_IDLE;
         default:                        w_state_next = ST_IDLE;
      endcase
   end

   // ---- capture / scan datapath (no reset: always loaded before use) ----
   always_ff @(posedge clk) begin
      if (r_state == ST_IDLE && w_capture) begin
         for (int i = 0; i < OUTPUT_SIZE; i++) begin
            r_buf[i] <= $signed(in_data[i*WIDTH +: WIDTH]);
         end
         r_max <= $signed(in_data[0 +: WIDTH]);
         r_idx <= '0;
      end else if (r_state == ST_SCAN && r_ptr != PTR_DONE) begin
         // Strictly greater keeps the lower index on ties.
         if (w_entry > r_max) begin
            r_max <= w_entry;
            r_idx <= w_scan_idx;
         end
      end
   end

   // ---- scan pointer and result registers ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr       <= '0;
         r_out_idx   <= '0;
         r_out_score <= '0;
         r_low_conf  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (w_capture) r_ptr <= PTR_W'(1);
            ST_SCAN: begin
               if (r_ptr == PTR_DONE) begin
                  r_out_idx   <= r_idx;
                  r_out_score <= r_max;
                  r_low_conf  <= is_low_conf(r_max);
               end else begin
                  r_ptr <= r_ptr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // ---- sticky overrun: captures dropped while busy ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                   r_overrun <= 1'b0;
      else if (clear_counts)                        r_overrun <= 1'b0;
      else if (w_capture && r_state != ST_IDLE)     r_overrun <= 1'b1;
   end

   class_counter_bank #(
      .OUTPUT_SIZE (OUTPUT_SIZE),
      .CNT_WIDTH   (CNT_WIDTH),
      .IDX_W       (IDX_W)
   ) u_counters (
      .clk         (clk),
      .reset       (reset),
      .inc         (w_accept),
      .inc_idx     (r_out_idx),
      .clear       (clear_counts),
      .class_count (class_count),
      .total_count (total_count)
   );

   assign out_valid   = (r_state == ST_HOLD);
   assign busy        = (r_state != ST_IDLE);
   assign class_idx   = r_out_idx;
   assign class_score = r_out_score;
   assign low_conf    = r_low_conf;
   assign overrun     = r_overrun;

endmodule
